// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS pipeline control blocks.
//   REG_ADDR_W  - register-file address width
//   ZERO_REG    - hard-wired zero register, never a hazard source
//   mem_state_e - data-memory wait FSM states
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_e;

endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: sequences multi-cycle data-memory accesses.
// Ports:
//   clk         in  clock, posedge
//   rst         in  synchronous active-high reset
//   mem_req     in  MEM-stage instruction is a load or store
//   pipe_freeze out request pending and memory not yet ready (ungated by rst)
// The access completes on its MEM_LATENCY-th cycle; the freeze is held for
// the MEM_LATENCY-1 cycles before that.
module mem_wait_fsm
  import mips_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic pipe_freeze
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  mem_state_e state;
  logic [3:0] cnt;
  logic       mem_ready;

  assign mem_ready   = (MEM_LATENCY == 1) || (state == WAIT && cnt == LAST_CNT);
  assign pipe_freeze = mem_req && !mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_req && !mem_ready) begin
            state <= WAIT;
            cnt   <= 4'd1;
          end
        end
        WAIT: begin
          // A squashed request abandons the access; the next one restarts it.
          if (!mem_req || mem_ready) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage MIPS core.
// Detects RAW hazards on the ID instruction, freezes the pipe during
// multi-cycle memory accesses and flushes IF/ID on a taken branch.
// Optional feature macro: FORWARD_EN (forwarding present downstream, only
// load-use hazards stall; default build does full EX/MEM comparison).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_src1, id_src2, id_two_src   ID-stage source operands
//   exe_dest, exe_wb_en, exe_mem_read  EX-stage destination info
//   mem_dest, mem_wb_en, mem_req   MEM-stage destination / access info
//   branch_taken                   ID resolved a taken branch or jump
//   pc_freeze, if_freeze, if_flush, id_bubble, pipe_freeze  control outputs
//   hazard_cnt                     saturating count of hazard-stall cycles
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 4,
  parameter int unsigned HAZ_CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  mem_req,
  input  logic                  branch_taken,
  output logic                  pc_freeze,
  output logic                  if_freeze,
  output logic                  if_flush,
  output logic                  id_bubble,
  output logic                  pipe_freeze,
  output logic [HAZ_CNT_W-1:0]  hazard_cnt
);

  logic                 mem_freeze;
  logic                 hazard;
  logic                 unused_in;
  logic [HAZ_CNT_W-1:0] hazard_cnt_q;

  mem_wait_fsm #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_mem_wait_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .pipe_freeze(mem_freeze)
  );

`ifdef FORWARD_EN
  // Forwarding covers everything except a load result needed immediately.
  assign hazard = exe_mem_read && exe_wb_en && (exe_dest != ZERO_REG) &&
                  ((exe_dest == id_src1) || (id_two_src && exe_dest == id_src2));
  assign unused_in = ^{mem_dest, mem_wb_en};
`else
  logic match1;
  logic match2;

  assign match1 = (id_src1 != ZERO_REG) &&
                  ((exe_wb_en && exe_dest == id_src1) || (mem_wb_en && mem_dest == id_src1));
  assign match2 = (id_src2 != ZERO_REG) &&
                  ((exe_wb_en && exe_dest == id_src2) || (mem_wb_en && mem_dest == id_src2));
  assign hazard    = match1 || (id_two_src && match2);
  assign unused_in = exe_mem_read;
`endif

  // Freeze outranks hazard: the hazard is re-evaluated once the pipe moves.
  // A hazard outranks a branch because the branch operands are stale.
  always_comb begin
    pc_freeze   = 1'b0;
    if_freeze   = 1'b0;
    if_flush    = 1'b0;
    id_bubble   = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst) begin
      if (mem_freeze) begin
        pc_freeze   = 1'b1;
        if_freeze   = 1'b1;
        pipe_freeze = 1'b1;
      end else if (hazard) begin
        pc_freeze = 1'b1;
        if_freeze = 1'b1;
        id_bubble = 1'b1;
      end else if (branch_taken) begin
        if_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hazard_cnt_q <= '0;
    end else if (hazard && !mem_freeze && (hazard_cnt_q != {HAZ_CNT_W{1'b1}})) begin
      hazard_cnt_q <= hazard_cnt_q + {{(HAZ_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl.
// A second instance with a 2-bit hazard counter shares all inputs and checks
// saturation.
module tb_hazard_ctrl;

  typedef struct {
    string       name;
    logic [4:0]  ctrl;  // {pc_freeze, if_freeze, if_flush, id_bubble, pipe_freeze}
    logic [15:0] cnt;
    logic [1:0]  sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
  logic       id_two_src = 1'b0, exe_wb_en = 1'b0, exe_mem_read = 1'b0;
  logic       mem_wb_en = 1'b0, mem_req = 1'b0, branch_taken = 1'b0;

  logic        pc_freeze, if_freeze, if_flush, id_bubble, pipe_freeze;
  logic        pc_freeze_s, if_freeze_s, if_flush_s, id_bubble_s, pipe_freeze_s;
  logic [15:0] hazard_cnt;
  logic [1:0]  hazard_cnt_s;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   run_cnt = 0;
  logic [4:0] e_two;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MEM_LATENCY(4),
    .HAZ_CNT_W  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .exe_dest    (exe_dest),
    .exe_wb_en   (exe_wb_en),
    .exe_mem_read(exe_mem_read),
    .mem_dest    (mem_dest),
    .mem_wb_en   (mem_wb_en),
    .mem_req     (mem_req),
    .branch_taken(branch_taken),
    .pc_freeze   (pc_freeze),
    .if_freeze   (if_freeze),
    .if_flush    (if_flush),
    .id_bubble   (id_bubble),
    .pipe_freeze (pipe_freeze),
    .hazard_cnt  (hazard_cnt)
  );

  hazard_ctrl #(
    .MEM_LATENCY(4),
    .HAZ_CNT_W  (2)
  ) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .exe_dest    (exe_dest),
    .exe_wb_en   (exe_wb_en),
    .exe_mem_read(exe_mem_read),
    .mem_dest    (mem_dest),
    .mem_wb_en   (mem_wb_en),
    .mem_req     (mem_req),
    .branch_taken(branch_taken),
    .pc_freeze   (pc_freeze_s),
    .if_freeze   (if_freeze_s),
    .if_flush    (if_flush_s),
    .id_bubble   (id_bubble_s),
    .pipe_freeze (pipe_freeze_s),
    .hazard_cnt  (hazard_cnt_s)
  );

  // Apply one vector just after the edge and queue its expected response.
  task automatic step(input string name, input logic r,
                      input logic [4:0] s1, input logic [4:0] s2, input logic two,
                      input logic [4:0] ed, input logic ewb, input logic emr,
                      input logic [4:0] md, input logic mwb,
                      input logic mreq, input logic br, input logic [4:0] exp_ctrl);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_src1 = s1; id_src2 = s2; id_two_src = two;
    exe_dest = ed; exe_wb_en = ewb; exe_mem_read = emr;
    mem_dest = md; mem_wb_en = mwb; mem_req = mreq; branch_taken = br;
    e.name = name;
    e.ctrl = exp_ctrl;
    e.cnt  = 16'(run_cnt);
    e.sat  = (run_cnt > 3) ? 2'd3 : 2'(run_cnt);
    sb.push_back(e);
    if (r) run_cnt = 0;
    else if (exp_ctrl[1]) run_cnt++;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks += 3;
      if ({pc_freeze, if_freeze, if_flush, id_bubble, pipe_freeze} != mon_e.ctrl) begin
        errors++;
        $display("FAIL %s ctrl got %b want %b", mon_e.name,
                 {pc_freeze, if_freeze, if_flush, id_bubble, pipe_freeze}, mon_e.ctrl);
      end
      if (hazard_cnt != mon_e.cnt) begin
        errors++;
        $display("FAIL %s hazard_cnt got %0d want %0d", mon_e.name, hazard_cnt, mon_e.cnt);
      end
      if (hazard_cnt_s != mon_e.sat) begin
        errors++;
        $display("FAIL %s hazard_cnt_sat got %0d want %0d", mon_e.name, hazard_cnt_s, mon_e.sat);
      end
    end
  end

  initial begin
`ifdef FORWARD_EN
    e_two = 5'b00000;
`else
    e_two = 5'b11010;
`endif
    // Reset held with a pending memory request.
    repeat (2) step("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000);
    // Two back-to-back memory accesses: 1,1,1,0,1,1,1,0.
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 3; j++) step("mem_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11001);
      step("mem_go", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000);
    end
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    // Load-use on src1.
    step("load_use", 0, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 5'b11010);
    step("load_use_done", 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    // MEM-stage match on src2 only stalls without forwarding and with two sources.
    step("mem_src2", 0, 3, 7, 1, 0, 0, 0, 7, 1, 0, 0, e_two);
    step("mem_src2_one_src", 0, 3, 7, 0, 0, 0, 0, 7, 1, 0, 0, 5'b00000);
    step("r0", 0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 5'b00000);
    // Branches.
    step("branch", 0, 1, 2, 1, 3, 1, 0, 4, 1, 0, 1, 5'b00100);
    step("branch_off", 0, 1, 2, 1, 3, 1, 0, 4, 1, 0, 0, 5'b00000);
    step("branch_hazard", 0, 5, 0, 0, 5, 1, 1, 0, 0, 0, 1, 5'b11010);
    // Hazard during a memory freeze: freeze only, hazard applies afterwards.
    for (int j = 0; j < 3; j++) step("haz_mem", 0, 5, 0, 0, 5, 1, 1, 0, 0, 1, 0, 5'b11001);
    step("haz_after_mem", 0, 5, 0, 0, 5, 1, 1, 0, 0, 1, 0, 5'b11010);
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    // Long hazard run drives the 2-bit counter into saturation.
    repeat (5) step("haz_run", 0, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 5'b11010);
    step("idle_sat", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    // Squashed request restarts the full latency.
    step("squash_a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11001);
    step("squash_b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    for (int j = 0; j < 3; j++) step("restart", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11001);
    step("restart_go", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000);
    // Reset in the middle of WAIT.
    repeat (2) step("pre_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11001);
    step("mid_rst", 1, 5, 0, 0, 5, 1, 1, 0, 0, 1, 0, 5'b00000);
    for (int j = 0; j < 3; j++) step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11001);
    step("post_rst_go", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000);
    step("idle_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the freeze and flush inputs of the IF/ID stage register and the PC register, and the bubble input of the ID/EX register. It detects RAW data hazards on the instruction in ID and sequences multi-cycle data-memory accesses with an internal wait FSM. It also squashes the fetched instruction when ID resolves a taken branch.

## Interface
Parameters:
- MEM_LATENCY, 4, cycles per data-memory access; legal range 1..15.
- HAZ_CNT_W, 16, width of the hazard-stall counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- id_src1  in  5  ID-stage source register 1.
- id_src2  in  5  ID-stage source register 2.
- id_two_src  in  1  ID instruction reads src2 (R-type, store, branch).
- exe_dest  in  5  EX-stage destination register.
- exe_wb_en  in  1  EX instruction writes back.
- exe_mem_read  in  1  EX instruction is a load.
- mem_dest  in  5  MEM-stage destination register.
- mem_wb_en  in  1  MEM instruction writes back.
- mem_req  in  1  MEM instruction is a load or store.
- branch_taken  in  1  ID resolved a taken branch or jump.
- pc_freeze  out  1  hold the PC.
- if_freeze  out  1  to the IF/ID register freeze input.
- if_flush  out  1  to the IF/ID register flush input.
- id_bubble  out  1  load NOP into ID/EX.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- hazard_cnt  out  HAZ_CNT_W  saturating count of hazard-stall cycles.

## Operation
- match(s) = s != 0 && ((exe_wb_en && exe_dest == s) || (mem_wb_en && mem_dest == s)). R0 never hazards.
- hazard = match(id_src1) || (id_two_src && match(id_src2)). See Configuration for the forwarding variant.
- mem_ready = (MEM_LATENCY == 1) || (state == WAIT && cnt == MEM_LATENCY-1).
- pipe_freeze = mem_req && !mem_ready.

Output priority, all combinational:
1. rst: all control outputs 0.
2. pipe_freeze: pc_freeze = if_freeze = 1; if_flush = id_bubble = 0.
3. hazard: pc_freeze = if_freeze = id_bubble = 1; if_flush = 0; branch_taken is ignored because the branch operands are stale.
4. branch_taken: if_flush = 1; all other control outputs 0.
5. Otherwise: all control outputs 0.

Memory FSM, states IDLE and WAIT; cnt is 4 bits:
- IDLE: if mem_req && !mem_ready, go to WAIT with cnt <= 1.
- WAIT: if !mem_req, go to IDLE and clear cnt (request squashed). If mem_ready, go to IDLE and clear cnt. Otherwise cnt <= cnt + 1.
- Back-to-back memory instructions re-enter WAIT on the cycle after the return to IDLE.

hazard_cnt:
- Increments on each cycle where priority 3 applies (hazard with no pipe_freeze).
- Saturates at all-ones and does not wrap.

## Timing
- Reset values: state IDLE, cnt 0, hazard_cnt 0; all control outputs 0 during rst.
- A memory access freezes the pipeline for MEM_LATENCY-1 cycles. The pipeline advances on the MEM_LATENCY-th cycle.
- A hazard stall lasts as long as the condition holds:
  - with forwarding: 1 cycle per load-use;
  - without forwarding: up to 2 cycles.
- Branch flush affects exactly the cycle branch_taken is high with no stall.
- rst asserted mid-WAIT returns the FSM to IDLE on the next edge. The access is restarted by the next mem_req.
- A hazard and a memory freeze in the same cycle produce a freeze only, with no bubble and no count. The hazard is re-evaluated after the freeze.

## Configuration
- FORWARD_EN defined: a forwarding unit exists downstream. hazard reduces to load-use only: exe_mem_read && exe_wb_en && exe_dest != 0, with exe_dest matching id_src1, or matching id_src2 when id_two_src. MEM-stage comparisons are removed.
- FORWARD_EN undefined: full EX and MEM comparison as described in Operation.

## Structure
- mips_pkg holds:
  - REG_ADDR_W = 5;
  - ZERO_REG = 5'd0;
  - the memory-FSM state enum (IDLE, WAIT).
- Sub-module mem_wait_fsm contains the FSM, cnt and mem_ready, and outputs pipe_freeze. hazard_ctrl keeps the comparators, the priority logic and hazard_cnt.

## Test plan
- Reset: hold rst 2 cycles with mem_req = 1 → all control outputs 0 and hazard_cnt = 0; the first cycle after reset has pipe_freeze = 1.
- Memory latency: MEM_LATENCY = 4, mem_req held → pipe_freeze = 1 for 3 cycles and 0 on the 4th; two consecutive loads → pattern 1,1,1,0,1,1,1,0.
- Load-use with FORWARD_EN: exe_mem_read = 1, exe_dest = 5, id_src1 = 5 → pc_freeze = if_freeze = id_bubble = 1 for 1 cycle; hazard_cnt = 1.
- Without forwarding: mem_wb_en = 1, mem_dest = 7, id_two_src = 1, id_src2 = 7 → stall; with id_two_src = 0 → no stall; any comparison against R0 → no stall.
- Branch: branch_taken = 1 with no hazard → if_flush = 1 for 1 cycle; branch_taken = 1 with a hazard → if_flush = 0 and id_bubble = 1.
- Priority and saturation: hazard and mem_req together → pipe_freeze = 1, id_bubble = 0, count unchanged; HAZ_CNT_W = 2 with 5 hazard cycles → hazard_cnt = 3.
